// File: rtl/nco_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl_pkg
//   Shared definitions for the NCO state-RAM sequencer:
//     - slot/word geometry and field offsets of the 51-bit state word
//     - sequencer state encoding
//     - the per-sample word update and the host read-modify-write merge
//   Word layout: [50:19] phase, [18] rst flag, [17:0] pitch increment.
// -----------------------------------------------------------------------------
package nco_sweep_ctrl_pkg;

   localparam int VOICES  = 8;
   localparam int V_OSC   = 8;
   localparam int V_WIDTH = 3;
   // Eight oscillators per voice need three index bits so that
   // slot = {voice, osc} covers all VOICES*V_OSC words.
   localparam int O_WIDTH = 3;
   localparam int SLOT_W  = V_WIDTH + O_WIDTH;
   localparam int NSLOT   = VOICES * V_OSC;

   localparam int PH_W    = 32;
   localparam int PI_W    = 18;
   localparam int WORD_W  = PH_W + 1 + PI_W;

   localparam int PH_LSB  = 19;
   localparam int RST_BIT = 18;
   localparam int PI_MSB  = 17;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SWEEP  = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_H_RD   = 3'd3,
      ST_H_WAIT = 3'd4,
      ST_H_WR   = 3'd5
   } state_t;

   // Per-sample update: a pending note-on zeroes the phase and consumes the
   // flag; otherwise the phase advances by the zero-extended pitch, wrapping.
   function automatic logic [WORD_W-1:0] phase_update(input logic [WORD_W-1:0] word);
      logic [PH_W-1:0]   phase;
      logic [PI_W-1:0]   pitch;
      logic [WORD_W-1:0] res;
      phase = word[PH_LSB +: PH_W];
      pitch = word[PI_MSB:0];
      res   = word;
      if (word[RST_BIT]) begin
         res[PH_LSB +: PH_W] = '0;
         res[RST_BIT]        = 1'b0;
      end else begin
         res[PH_LSB +: PH_W] = phase + PH_W'(pitch);
      end
      return res;
   endfunction

   // Host merge: the phase is never touched; the pitch is replaced and/or the
   // rst flag is set. With neither request the word goes back unchanged.
   function automatic logic [WORD_W-1:0] host_merge(
      input logic [WORD_W-1:0] word,
      input logic              set_pitch,
      input logic [PI_W-1:0]   pitch,
      input logic              note_on
   );
      logic [WORD_W-1:0] res;
      res = word;
      if (set_pitch) res[PI_MSB:0] = pitch;
      if (note_on)   res[RST_BIT]  = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/nco_sweep_ctrl_update.sv
// -----------------------------------------------------------------------------
// nco_phase_update
//   Purely combinational state-word update used on the sweep write-back path.
//   Ports:
//     word_in   in  WORD_W  word as read from the state RAM
//     word_out  out WORD_W  word to write back (new phase in [50:19])
// -----------------------------------------------------------------------------
module nco_phase_update
   import nco_sweep_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] word_in,
   output logic [WORD_W-1:0] word_out
);

   assign word_out = phase_update(word_in);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//   Sequencer/arbiter for the NCO state RAM port A. Each sample tick sweeps
//   every slot through read -> update -> write-back and streams the new phase
//   to the wavetable stage. Between sweeps, single host read-modify-writes
//   (pitch set / note-on) are granted.
//
//   RAM timing: a read address in cycle c returns ram_qa in c+2; a write uses
//   the address presented one cycle before ram_we/ram_d.
//
//   Host handshake: host_req is held with its payload until host_ack. host_ack
//   is a single-cycle pulse in the cycle after acceptance; the payload is
//   captured when accepted, so the host may change it once host_ack is seen.
//   Requests are only accepted in IDLE with no tick pending; otherwise they
//   simply wait.
//
//   Ports:
//     sCLK_XVXENVS       in   clock (also the RAM clock)
//     reset              in   synchronous, active-high
//     sample_tick        in   1-cycle pulse, requests a sweep
//     host_req/host_ack  in/out request handshake
//     host_slot          in   target slot {voice,osc}
//     host_set_pitch     in   replace pitch field with host_pitch
//     host_pitch         in   new pitch increment
//     host_note_on       in   set rst flag (phase zeroed on next sweep)
//     ram_reada_address  out  port A read address
//     ram_qa             in   port A read data
//     ram_write_address  out  write address (leads ram_we/ram_d by a cycle)
//     ram_d / ram_we     out  write data / enable
//     phase_valid        out  phase_slot/phase_out valid
//     phase_slot         out  slot of phase_out
//     phase_out          out  updated phase
//     busy               out  sequencer not idle
//     overrun            out  sticky: tick arrived while one was still pending
//     state_dbg          out  current sequencer state
// -----------------------------------------------------------------------------
module nco_sweep_ctrl
   import nco_sweep_ctrl_pkg::*;
(
   input  logic              sCLK_XVXENVS,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic              host_req,
   output logic              host_ack,
   input  logic [SLOT_W-1:0] host_slot,
   input  logic              host_set_pitch,
   input  logic [PI_W-1:0]   host_pitch,
   input  logic              host_note_on,
   output logic [SLOT_W-1:0] ram_reada_address,
   input  logic [WORD_W-1:0] ram_qa,
   output logic [SLOT_W-1:0] ram_write_address,
   output logic [WORD_W-1:0] ram_d,
   output logic              ram_we,
   output logic              phase_valid,
   output logic [SLOT_W-1:0] phase_slot,
   output logic [PH_W-1:0]   phase_out,
   output logic              busy,
   output logic              overrun,
   output logic [2:0]        state_dbg
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] cnt_q;
   logic              tick_pend_q;
   logic              overrun_q;

   // Sweep read pipeline: stage 1 = address held for the write, stage 2 =
   // data returned from RAM and written back.
   logic              rd_v1_q, rd_v2_q;
   logic [SLOT_W-1:0] slot1_q, slot2_q;

   // Latched host request.
   logic [SLOT_W-1:0] h_slot_q;
   logic              h_set_q;
   logic [PI_W-1:0]   h_pitch_q;
   logic              h_note_q;

   logic              sweep_start;
   logic              host_accept;
   logic [WORD_W-1:0] upd_word;
   logic [WORD_W-1:0] host_word;

   nco_phase_update u_update (
      .word_in  (ram_qa),
      .word_out (upd_word)
   );

   assign host_word = host_merge(ram_qa, h_set_q, h_pitch_q, h_note_q);

   // ---------------------------------------------------------------- FSM next
   always_comb begin
      state_d     = state_q;
      sweep_start = 1'b0;
      host_accept = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A pending tick always wins over the host.
            if (tick_pend_q) begin
               state_d     = ST_SWEEP;
               sweep_start = 1'b1;
            end else if (host_req) begin
               state_d     = ST_H_RD;
               host_accept = 1'b1;
            end
         end
         ST_SWEEP: begin
            if (cnt_q == LAST_SLOT) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Leave once stage 1 is empty: the final write-back issues now.
            if (!rd_v1_q) state_d = ST_IDLE;
         end
         ST_H_RD:   state_d = ST_H_WAIT;
         ST_H_WAIT: state_d = ST_H_WR;
         ST_H_WR:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- FSM register
   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_SWEEP) cnt_q <= cnt_q + SLOT_W'(1);
         else                     cnt_q <= '0;
      end
   end

   // ------------------------------------------------------- tick bookkeeping
   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset) begin
         tick_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (sample_tick) begin
            // A tick on top of an unconsumed one is dropped and flagged. A
            // tick in the very cycle the pending one is consumed is not lost.
            if (tick_pend_q && !sweep_start) overrun_q <= 1'b1;
            tick_pend_q <= 1'b1;
         end else if (sweep_start) begin
            tick_pend_q <= 1'b0;
         end
      end
   end

   // --------------------------------------------------------- sweep pipeline
   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset) begin
         rd_v1_q <= 1'b0;
         rd_v2_q <= 1'b0;
         slot1_q <= '0;
         slot2_q <= '0;
      end else begin
         rd_v1_q <= (state_q == ST_SWEEP);
         rd_v2_q <= rd_v1_q;
         slot1_q <= cnt_q;
         slot2_q <= slot1_q;
      end
   end

   // ----------------------------------------------------------- host latch
   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset) begin
         h_slot_q  <= '0;
         h_set_q   <= 1'b0;
         h_pitch_q <= '0;
         h_note_q  <= 1'b0;
      end else if (host_accept) begin
         h_slot_q  <= host_slot;
         h_set_q   <= host_set_pitch;
         h_pitch_q <= host_pitch;
         h_note_q  <= host_note_on;
      end
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      busy              = (state_q != ST_IDLE);
      host_ack          = (state_q == ST_H_RD);
      overrun           = overrun_q;
      state_dbg         = state_q;

      ram_reada_address = '0;
      if (state_q == ST_SWEEP)     ram_reada_address = cnt_q;
      else if (state_q == ST_H_RD) ram_reada_address = h_slot_q;

      // Sweep and host traffic never overlap: host work only starts after
      // the drain has emptied the pipeline.
      ram_write_address = '0;
      if (rd_v1_q)                   ram_write_address = slot1_q;
      else if (state_q == ST_H_WAIT) ram_write_address = h_slot_q;

      ram_we      = 1'b0;
      ram_d       = '0;
      phase_valid = 1'b0;
      phase_slot  = '0;
      phase_out   = '0;
      if (rd_v2_q) begin
         ram_we      = 1'b1;
         ram_d       = upd_word;
         phase_valid = 1'b1;
         phase_slot  = slot2_q;
         phase_out   = upd_word[PH_LSB +: PH_W];
      end else if (state_q == ST_H_WR) begin
         ram_we = 1'b1;
         ram_d  = host_word;
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;
  import nco_sweep_ctrl_pkg::*;

  localparam int SE_W = SLOT_W + PH_W;

  // ---------------------------------------------------------------- signals
  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick;
  logic              host_req;
  logic              host_ack;
  logic [SLOT_W-1:0] host_slot;
  logic              host_set_pitch;
  logic [PI_W-1:0]   host_pitch;
  logic              host_note_on;
  logic [SLOT_W-1:0] ram_reada_address;
  logic [WORD_W-1:0] ram_qa;
  logic [SLOT_W-1:0] ram_write_address;
  logic [WORD_W-1:0] ram_d;
  logic              ram_we;
  logic              phase_valid;
  logic [SLOT_W-1:0] phase_slot;
  logic [PH_W-1:0]   phase_out;
  logic              busy;
  logic              overrun;
  logic [2:0]        state_dbg;

  nco_sweep_ctrl dut (
    .sCLK_XVXENVS      (clk),
    .reset             (reset),
    .sample_tick       (sample_tick),
    .host_req          (host_req),
    .host_ack          (host_ack),
    .host_slot         (host_slot),
    .host_set_pitch    (host_set_pitch),
    .host_pitch        (host_pitch),
    .host_note_on      (host_note_on),
    .ram_reada_address (ram_reada_address),
    .ram_qa            (ram_qa),
    .ram_write_address (ram_write_address),
    .ram_d             (ram_d),
    .ram_we            (ram_we),
    .phase_valid       (phase_valid),
    .phase_slot        (phase_slot),
    .phase_out         (phase_out),
    .busy              (busy),
    .overrun           (overrun),
    .state_dbg         (state_dbg)
  );

  // ------------------------------------------------------ clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------------------------------------------- state RAM model
  logic [WORD_W-1:0] mem [NSLOT];
  logic [WORD_W-1:0] preload [NSLOT];
  logic              do_load = 1'b0;
  logic [SLOT_W-1:0] ra1, wa1;

  always @(posedge clk) begin
    ra1    <= ram_reada_address;
    ram_qa <= mem[ra1];
    wa1    <= ram_write_address;
    if (do_load) begin
      for (int i = 0; i < NSLOT; i++) mem[i] <= preload[i];
    end else if (ram_we) begin
      mem[wa1] <= ram_d;
    end
  end

  // --------------------------------------------------------------- monitor
  logic [SE_W-1:0] got_q[$];
  int              wr_cyc[$];
  logic [SLOT_W-1:0] wr_addr[$];
  int              busy_cycles = 0;

  always @(negedge clk) begin
    if (phase_valid) got_q.push_back({phase_slot, phase_out});
    if (ram_we) begin
      wr_addr.push_back(wa1);
      wr_cyc.push_back(cyc);
    end
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  // ------------------------------------------------------------ scoreboard
  logic [SE_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic score_sweep(input int base, input string name);
    int idx;
    logic [SE_W-1:0] e;
    check({name, " valid count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (idx < got_q.size()) check({name, " slot/phase"}, 64'(got_q[idx]), 64'(e));
      idx++;
    end
  endtask

  // ----------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    do_load = 1'b1;
    step();
    do_load = 1'b0;
  endtask

  task automatic pulse_tick(output int t);
    sample_tick = 1'b1;
    t = cyc;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_quiet(input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < budget) begin
      step();
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle wait expired", 64'(quiet < 3), 64'(0));
  endtask

  task automatic host_rmw(input logic [SLOT_W-1:0] slot, input logic sp,
                          input logic [PI_W-1:0] pitch, input logic no,
                          output int ack_at);
    host_slot = slot;
    host_set_pitch = sp;
    host_pitch = pitch;
    host_note_on = no;
    host_req = 1'b1;
    ack_at = -1;
    for (int k = 0; k < 200 && ack_at < 0; k++) begin
      @(negedge clk);
      if (host_ack) ack_at = cyc;
      step();
    end
    host_req = 1'b0;
    host_set_pitch = 1'b0;
    host_note_on = 1'b0;
    check("host ack seen", 64'(ack_at < 0), 64'(0));
  endtask

  function automatic logic [WORD_W-1:0] mk(input logic [PH_W-1:0] ph, input logic r,
                                           input logic [PI_W-1:0] pi);
    return {ph, r, pi};
  endfunction

  // ----------------------------------------------------------- vector tables
  typedef struct {
    logic [SLOT_W-1:0] slot;
    logic [WORD_W-1:0] init;
    logic [PH_W-1:0]   exp_phase;
    logic [WORD_W-1:0] exp_word;
  } upd_vec_t;

  typedef struct {
    logic [SLOT_W-1:0] slot;
    logic              sp;
    logic [PI_W-1:0]   pitch;
    logic              no;
    logic [WORD_W-1:0] init;
    logic [WORD_W-1:0] exp_word;
  } host_vec_t;

  upd_vec_t  uv[6];
  host_vec_t hv[5];

  // -------------------------------------------------------------- test body
  initial begin
    int t, t2, t3, ack_at, h, base, wbase, b0, w5, n0, found;
    logic [SE_W-1:0] e;
    logic [PH_W-1:0] ph9;
    logic [WORD_W-1:0] exp_w [NSLOT];
    logic [PH_W-1:0]   exp_p [NSLOT];

    uv[0] = '{6'd0,  mk(32'h0000_0000, 1'b0, 18'h00001), 32'h0000_0001, mk(32'h0000_0001, 1'b0, 18'h00001)};
    uv[1] = '{6'd5,  mk(32'hFFFF_FFFF, 1'b0, 18'h00002), 32'h0000_0001, mk(32'h0000_0001, 1'b0, 18'h00002)};
    uv[2] = '{6'd10, mk(32'h1234_5678, 1'b1, 18'h3FFFF), 32'h0000_0000, mk(32'h0000_0000, 1'b0, 18'h3FFFF)};
    uv[3] = '{6'd20, mk(32'h0000_0007, 1'b0, 18'h00000), 32'h0000_0007, mk(32'h0000_0007, 1'b0, 18'h00000)};
    uv[4] = '{6'd33, mk(32'hFFFC_0001, 1'b0, 18'h3FFFF), 32'h0000_0000, mk(32'h0000_0000, 1'b0, 18'h3FFFF)};
    uv[5] = '{6'd63, mk(32'h8000_0000, 1'b0, 18'h3FFFF), 32'h8003_FFFF, mk(32'h8003_FFFF, 1'b0, 18'h3FFFF)};

    hv[0] = '{6'd1,  1'b1, 18'h2AAAA, 1'b0, mk(32'h1111_1111, 1'b0, 18'h00001), mk(32'h1111_1111, 1'b0, 18'h2AAAA)};
    hv[1] = '{6'd2,  1'b0, 18'h3FFFF, 1'b1, mk(32'h2222_2222, 1'b0, 18'h00007), mk(32'h2222_2222, 1'b1, 18'h00007)};
    hv[2] = '{6'd3,  1'b1, 18'h3FFFF, 1'b1, mk(32'hDEAD_BEEF, 1'b0, 18'h00000), mk(32'hDEAD_BEEF, 1'b1, 18'h3FFFF)};
    hv[3] = '{6'd4,  1'b0, 18'h15555, 1'b0, mk(32'hCAFE_F00D, 1'b1, 18'h12345), mk(32'hCAFE_F00D, 1'b1, 18'h12345)};
    hv[4] = '{6'd62, 1'b1, 18'h00000, 1'b0, mk(32'h0000_0001, 1'b1, 18'h3FFFF), mk(32'h0000_0001, 1'b1, 18'h00000)};

    reset = 1'b1;
    sample_tick = 1'b0;
    host_req = 1'b0;
    host_slot = '0;
    host_set_pitch = 1'b0;
    host_pitch = '0;
    host_note_on = 1'b0;

    // ---- reset state
    repeat (3) step();
    @(negedge clk);
    check("rst busy", 64'(busy), 64'(0));
    check("rst ram_we", 64'(ram_we), 64'(0));
    check("rst host_ack", 64'(host_ack), 64'(0));
    check("rst phase_valid", 64'(phase_valid), 64'(0));
    check("rst phase_slot", 64'(phase_slot), 64'(0));
    check("rst phase_out", 64'(phase_out), 64'(0));
    check("rst ram_d", 64'(ram_d), 64'(0));
    check("rst read addr", 64'(ram_reada_address), 64'(0));
    check("rst write addr", 64'(ram_write_address), 64'(0));
    check("rst overrun", 64'(overrun), 64'(0));
    check("rst state", 64'(state_dbg), 64'(0));
    step();
    reset = 1'b0;
    step();

    // ---- full sweep, every word pitch=1
    for (int i = 0; i < NSLOT; i++) preload[i] = mk(32'h0, 1'b0, 18'd1);
    load_mem();
    base = got_q.size();
    b0 = busy_cycles;
    pulse_tick(t);
    wait_quiet(300);
    for (int i = 0; i < NSLOT; i++) exp_q.push_back({SLOT_W'(i), 32'd1});
    score_sweep(base, "sweep1");
    check("sweep1 length", 64'(busy_cycles - b0), 64'(NSLOT + 2));
    for (int i = 0; i < NSLOT; i++) check("sweep1 ram word", 64'(mem[i]), 64'(mk(32'd1, 1'b0, 18'd1)));

    // ---- table-driven update vectors
    for (int i = 0; i < NSLOT; i++) begin
      preload[i] = '0;
      exp_w[i] = '0;
      exp_p[i] = '0;
    end
    for (int v = 0; v < 6; v++) begin
      preload[uv[v].slot] = uv[v].init;
      exp_w[uv[v].slot] = uv[v].exp_word;
      exp_p[uv[v].slot] = uv[v].exp_phase;
    end
    load_mem();
    base = got_q.size();
    wbase = wr_cyc.size();
    pulse_tick(t);
    wait_quiet(300);
    for (int i = 0; i < NSLOT; i++) exp_q.push_back({SLOT_W'(i), exp_p[i]});
    score_sweep(base, "table sweep");
    for (int v = 0; v < 6; v++) check("table ram word", 64'(mem[uv[v].slot]), 64'(uv[v].exp_word));
    check("table write count", 64'(wr_cyc.size() - wbase), 64'(NSLOT));
    w5 = -1;
    for (int j = wbase; j < wr_cyc.size(); j++)
      if (wr_addr[j] == SLOT_W'(5) && w5 < 0) w5 = wr_cyc[j];
    check("slot5 write cycle", 64'(w5), 64'(t + 4 + 5));

    // ---- note-on slot 9 in IDLE, then a sweep consumes it
    for (int i = 0; i < NSLOT; i++) preload[i] = '0;
    preload[9] = mk(32'h0000_ABCD, 1'b0, 18'h00005);
    load_mem();
    step();
    h = cyc;
    host_rmw(6'd9, 1'b0, 18'h0, 1'b1, ack_at);
    check("note-on ack latency", 64'(ack_at), 64'(h + 1));
    wait_until(h + 5);
    check("note-on word", 64'(mem[9]), 64'(mk(32'h0000_ABCD, 1'b1, 18'h00005)));
    check("note-on neighbour 8", 64'(mem[8]), 64'(0));
    check("note-on neighbour 10", 64'(mem[10]), 64'(0));
    base = got_q.size();
    pulse_tick(t);
    wait_quiet(300);
    found = 0;
    ph9 = '1;
    for (int j = base; j < got_q.size(); j++) begin
      e = got_q[j];
      if (e[PH_W +: SLOT_W] == SLOT_W'(9) && found == 0) begin
        found = 1;
        ph9 = e[PH_W-1:0];
      end
    end
    check("note-on slot9 streamed", 64'(found), 64'(1));
    check("note-on slot9 phase", 64'(ph9), 64'(0));
    check("note-on slot9 after sweep", 64'(mem[9]), 64'(mk(32'h0, 1'b0, 18'h00005)));

    // ---- table-driven host read-modify-writes
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NSLOT; i++) preload[i] = '0;
      preload[hv[v].slot] = hv[v].init;
      load_mem();
      wbase = wr_cyc.size();
      host_rmw(hv[v].slot, hv[v].sp, hv[v].pitch, hv[v].no, ack_at);
      wait_quiet(50);
      check("host rmw word", 64'(mem[hv[v].slot]), 64'(hv[v].exp_word));
      check("host rmw write count", 64'(wr_cyc.size() - wbase), 64'(1));
      if (wr_addr.size() > wbase) check("host rmw write addr", 64'(wr_addr[wbase]), 64'(hv[v].slot));
    end

    // ---- host request raised mid-sweep waits for IDLE
    for (int i = 0; i < NSLOT; i++) preload[i] = '0;
    preload[0] = mk(32'h0000_0100, 1'b0, 18'h00010);
    load_mem();
    pulse_tick(t);
    wait_until(t + 12);
    check("mid-sweep busy", 64'(busy), 64'(1));
    host_rmw(6'd0, 1'b1, 18'h01234, 1'b0, ack_at);
    check("mid-sweep ack cycle", 64'(ack_at), 64'(t + NSLOT + 5));
    wait_quiet(50);
    check("mid-sweep slot0 word", 64'(mem[0]), 64'(mk(32'h0000_0110, 1'b0, 18'h01234)));

    // ---- overrun: three ticks, the third while the second is still pending
    for (int i = 0; i < NSLOT; i++) preload[i] = '0;
    load_mem();
    check("overrun clear before", 64'(overrun), 64'(0));
    base = got_q.size();
    pulse_tick(t);
    wait_until(t + 10);
    pulse_tick(t2);
    @(negedge clk);
    check("overrun after 2nd tick", 64'(overrun), 64'(0));
    wait_until(t + 20);
    pulse_tick(t3);
    @(negedge clk);
    check("overrun after 3rd tick", 64'(overrun), 64'(1));
    wait_quiet(600);
    n0 = 0;
    for (int j = base; j < got_q.size(); j++) begin
      e = got_q[j];
      if (e[PH_W +: SLOT_W] == '0) n0++;
    end
    check("overrun sweep count", 64'(n0), 64'(2));
    check("overrun valid total", 64'(got_q.size() - base), 64'(2 * NSLOT));
    check("overrun sticky", 64'(overrun), 64'(1));

    // ---- reset while the sweep reads slot 20
    for (int i = 0; i < NSLOT; i++) preload[i] = mk(32'h0, 1'b0, 18'd1);
    load_mem();
    pulse_tick(t);
    wait_until(t + 22);
    @(negedge clk);
    check("abort read addr", 64'(ram_reada_address), 64'(20));
    reset = 1'b1;
    step();
    @(negedge clk);
    check("abort ram_we", 64'(ram_we), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort overrun", 64'(overrun), 64'(0));
    check("abort phase_valid", 64'(phase_valid), 64'(0));
    step();
    reset = 1'b0;
    repeat (4) step();
    for (int i = 0; i < NSLOT; i++) begin
      if (i < 19) check("abort written slot", 64'(mem[i]), 64'(mk(32'd1, 1'b0, 18'd1)));
      else        check("abort unwritten slot", 64'(mem[i]), 64'(mk(32'd0, 1'b0, 18'd1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
